// File: rtl/vliw_pkg.sv
// Shared types and default widths for the VLIW writeback stage and its
// companion units, for example the forwarding unit.
package vliw_pkg;

    localparam int LANES_DEF  = 4;
    localparam int REG_W_DEF  = 7;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        WAIT   = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_W_DEF-1:0]  rd;
        logic [DATA_W_DEF-1:0] data;
        logic                  load;
    } wb_lane_t;

endpackage

// File: rtl/wb_rd_dedup.sv
// Per-lane write enables for a bundle. x0 is never written, and when two
// lanes share a destination the highest-indexed lane wins.
module wb_rd_dedup
    import vliw_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int REG_W = REG_W_DEF
) (
    input  logic                   commit,
    input  logic [LANES-1:0]       valid,
    input  logic [LANES*REG_W-1:0] rd,
    output logic [LANES-1:0]       we
);

    logic [LANES-1:0] shadowed;

    always_comb begin
        shadowed = '0;
        we       = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (valid[j] && (rd[j*REG_W +: REG_W] == rd[i*REG_W +: REG_W]))
                    shadowed[i] = 1'b1;
            end
            we[i] = commit && valid[i] && (rd[i*REG_W +: REG_W] != '0) && !shadowed[i];
        end
    end

endmodule

// File: rtl/vliw_writeback_ctl.sv
// Writeback bundle register. It inserts bubbles on stall and flush, holds a
// single outstanding load until memory returns, and resolves per-lane write enables.
module vliw_writeback_ctl
    import vliw_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES*REG_W-1:0]  in_rd,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic [LANES-1:0]        in_load,
    input  logic                    mem_rvalid,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [LANES-1:0]        wb_we,
    output logic [LANES*REG_W-1:0]  wb_rd,
    output logic [LANES*DATA_W-1:0] wb_data,
    output logic                    busy,
    output logic                    err_multi_load
);

    wb_state_e               state, next_state;
    logic [LANES-1:0]        vld_p1;
    logic [LANES-1:0]        load_p1;
    logic [LANES*REG_W-1:0]  rd_p1;
    logic [LANES*DATA_W-1:0] data_p1;
    logic                    err_q;
    logic                    commit;
    logic                    accept;
    logic [LANES-1:0]        in_ld;

    function automatic logic multi_hot(input logic [LANES-1:0] v);
        return (v & (v - LANES'(1))) != '0;
    endfunction

    function automatic int lowest_idx(input logic [LANES-1:0] v);
        int idx;
        idx = 0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    assign in_ld  = in_valid & in_load;
    assign accept = (state != WAIT) && !stall && !flush && (|in_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, COMMIT: begin
                if (accept && (|in_ld)) next_state = WAIT;
                else if (accept)        next_state = COMMIT;
                else                    next_state = IDLE;
            end
            WAIT:    if (mem_rvalid) next_state = COMMIT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        commit = 1'b0;
        case (state)
            WAIT:    busy   = 1'b1;
            COMMIT:  commit = 1'b1;
            default: ;
        endcase
    end

    // Execute -> writeback boundary; a returning load overwrites only its own lane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1  <= '0;
            load_p1 <= '0;
            rd_p1   <= '0;
            data_p1 <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            vld_p1  <= in_valid;
            load_p1 <= in_ld;
            rd_p1   <= in_rd;
            data_p1 <= in_data;
            if (multi_hot(in_ld)) err_q <= 1'b1;
        end else if ((state == WAIT) && mem_rvalid) begin
            data_p1[lowest_idx(vld_p1 & load_p1)*DATA_W +: DATA_W] <= mem_rdata;
        end
    end

    wb_rd_dedup #(
        .LANES (LANES),
        .REG_W (REG_W)
    ) u_dedup (
        .commit (commit),
        .valid  (vld_p1),
        .rd     (rd_p1),
        .we     (wb_we)
    );

    assign wb_rd          = rd_p1;
    assign wb_data        = data_p1;
    assign err_multi_load = err_q;

endmodule

// File: tb/tb_vliw_writeback_ctl.sv
// Directed bench for vliw_writeback_ctl with hand-computed expectations.
module tb_vliw_writeback_ctl;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall, flush;
    logic [3:0]   in_valid, in_load;
    logic [27:0]  in_rd;
    logic [127:0] in_data;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic [3:0]   wb_we;
    logic [27:0]  wb_rd;
    logic [127:0] wb_data;
    logic         busy;
    logic         err_multi_load;

    int checks   = 0;
    int failures = 0;

    vliw_writeback_ctl #(.LANES(4), .REG_W(7), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_rd          (in_rd),
        .in_data        (in_data),
        .in_load        (in_load),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .wb_we          (wb_we),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .busy           (busy),
        .err_multi_load (err_multi_load)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [27:0] rd,
                         input logic [127:0] d, input logic [3:0] ld);
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        in_load  = ld;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (wb_we !== 4'b0000) begin failures++; $display("FAIL reset_we got=%b exp=0000", wb_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (err_multi_load !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_multi_load); end
        checks++; if (wb_data !== 128'h0 || wb_rd !== 28'h0) begin failures++; $display("FAIL reset_bundle got rd=%h data=%h exp=0", wb_rd, wb_data); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic;
        drive(4'b1111, {7'd4, 7'd3, 7'd2, 7'd1},
              {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, 4'b0000);
        tick;
        checks++; if (wb_we !== 4'b1111) begin failures++; $display("FAIL basic_we got=%b exp=1111", wb_we); end
        checks++; if (wb_rd !== {7'd4, 7'd3, 7'd2, 7'd1}) begin failures++; $display("FAIL basic_rd got=%h exp=%h", wb_rd, {7'd4, 7'd3, 7'd2, 7'd1}); end
        checks++; if (wb_data !== {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}) begin failures++; $display("FAIL basic_data got=%h", wb_data); end
        drive(4'b0000, '0, '0, 4'b0000);
        tick;
        checks++; if (wb_we !== 4'b0000) begin failures++; $display("FAIL basic_bubble_we got=%b exp=0000", wb_we); end
        // Load flag on an invalid lane must not start a load.
        drive(4'b0101, {7'd4, 7'd3, 7'd2, 7'd1}, {4{32'h5A5A5A5A}}, 4'b0010);
        tick;
        checks++; if (wb_we !== 4'b0101 || busy !== 1'b0) begin failures++; $display("FAIL invalid_load got we=%b busy=%b exp we=0101 busy=0", wb_we, busy); end
        drive(4'b0000, '0, '0, 4'b0000);
        tick;
    endtask

    task automatic test_back_to_back;
        drive(4'b1111, {7'd8, 7'd7, 7'd6, 7'd5}, {32'h4, 32'h3, 32'h2, 32'h1}, 4'b0000);
        tick;
        checks++; if (wb_we !== 4'b1111 || wb_rd !== {7'd8, 7'd7, 7'd6, 7'd5}) begin failures++; $display("FAIL b2b_first got we=%b rd=%h", wb_we, wb_rd); end
        drive(4'b0011, {7'd0, 7'd0, 7'd10, 7'd9}, {32'h0, 32'h0, 32'h20, 32'h10}, 4'b0000);
        tick;
        checks++; if (wb_we !== 4'b0011 || wb_data[63:0] !== {32'h20, 32'h10}) begin failures++; $display("FAIL b2b_second got we=%b data=%h exp we=0011", wb_we, wb_data[63:0]); end
        drive(4'b0000, '0, '0, 4'b0000);
        tick;
        checks++; if (wb_we !== 4'b0000) begin failures++; $display("FAIL b2b_end got=%b exp=0000", wb_we); end
    endtask

    task automatic test_load;
        drive(4'b1111, {7'd4, 7'd3, 7'd5, 7'd1},
              {32'h30303030, 32'h20202020, 32'h10101010, 32'h00000000}, 4'b0010);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        tick;
        mem_rvalid = 1'b0;
        checks++; if (busy !== 1'b1 || wb_we !== 4'b0000) begin failures++; $display("FAIL load_t1 got busy=%b we=%b exp busy=1 we=0000", busy, wb_we); end
        drive(4'b1111, {7'd14, 7'd13, 7'd12, 7'd11}, {32'h44, 32'h33, 32'h22, 32'h11}, 4'b0000);
        tick;
        checks++; if (busy !== 1'b1 || wb_we !== 4'b0000) begin failures++; $display("FAIL load_t2 got busy=%b we=%b exp busy=1 we=0000", busy, wb_we); end
        tick;
        checks++; if (busy !== 1'b1 || wb_rd !== {7'd4, 7'd3, 7'd5, 7'd1}) begin failures++; $display("FAIL load_t3 got busy=%b rd=%h exp busy=1 held rd", busy, wb_rd); end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        tick;
        mem_rvalid = 1'b0;
        checks++; if (busy !== 1'b0 || wb_we !== 4'b1111) begin failures++; $display("FAIL load_commit got busy=%b we=%b exp busy=0 we=1111", busy, wb_we); end
        checks++; if (wb_data !== {32'h30303030, 32'h20202020, 32'hDEADBEEF, 32'h00000000} || wb_rd !== {7'd4, 7'd3, 7'd5, 7'd1}) begin failures++; $display("FAIL load_data got rd=%h data=%h", wb_rd, wb_data); end
        tick;
        checks++; if (wb_we !== 4'b1111 || wb_rd !== {7'd14, 7'd13, 7'd12, 7'd11}) begin failures++; $display("FAIL load_held_next got we=%b rd=%h", wb_we, wb_rd); end
        drive(4'b0000, '0, '0, 4'b0000);
        tick;
    endtask

    task automatic test_conflict;
        drive(4'b1111, {7'd0, 7'd7, 7'd0, 7'd7}, {32'h3, 32'h2, 32'h1, 32'h0}, 4'b0000);
        tick;
        checks++; if (wb_we !== 4'b0100) begin failures++; $display("FAIL conflict_x0 got=%b exp=0100", wb_we); end
        drive(4'b1111, {7'd9, 7'd3, 7'd9, 7'd3}, {32'h3, 32'h2, 32'h1, 32'h0}, 4'b0000);
        tick;
        checks++; if (wb_we !== 4'b1100) begin failures++; $display("FAIL conflict_pairs got=%b exp=1100", wb_we); end
        drive(4'b0000, '0, '0, 4'b0000);
        tick;
    endtask

    task automatic test_stall_flush;
        drive(4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, {4{32'h77777777}}, 4'b0000);
        stall = 1'b1;
        tick;
        checks++; if (wb_we !== 4'b0000) begin failures++; $display("FAIL stall_bubble got=%b exp=0000", wb_we); end
        stall = 1'b0;
        flush = 1'b1;
        tick;
        checks++; if (wb_we !== 4'b0000) begin failures++; $display("FAIL flush_bubble got=%b exp=0000", wb_we); end
        flush = 1'b0;
        drive(4'b0001, {7'd0, 7'd0, 7'd0, 7'd3}, {32'h0, 32'h0, 32'h0, 32'h99}, 4'b0001);
        tick;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_wait_busy got=%b exp=1", busy); end
        stall = 1'b1;
        drive(4'b1111, {7'd4, 7'd3, 7'd2, 7'd1}, {4{32'h88888888}}, 4'b0000);
        tick;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        tick;
        mem_rvalid = 1'b0;
        checks++; if (wb_we !== 4'b0001 || wb_data[31:0] !== 32'hCAFEF00D || busy !== 1'b0) begin failures++; $display("FAIL stall_wait_commit got we=%b d0=%h busy=%b exp we=0001 d0=cafef00d busy=0", wb_we, wb_data[31:0], busy); end
        tick;
        checks++; if (wb_we !== 4'b0000) begin failures++; $display("FAIL stall_after_commit got=%b exp=0000", wb_we); end
        stall = 1'b0;
        drive(4'b0000, '0, '0, 4'b0000);
        tick;
    endtask

    task automatic test_multi_load;
        drive(4'b1111, {7'd4, 7'd3, 7'd2, 7'd1},
              {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000}, 4'b1001);
        tick;
        checks++; if (err_multi_load !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL multi_capture got err=%b busy=%b exp 1 1", err_multi_load, busy); end
        drive(4'b0000, '0, '0, 4'b0000);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00000011;
        tick;
        mem_rvalid = 1'b0;
        checks++; if (wb_we !== 4'b1111) begin failures++; $display("FAIL multi_we got=%b exp=1111", wb_we); end
        checks++; if (wb_data !== {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000011}) begin failures++; $display("FAIL multi_data got=%h", wb_data); end
        tick;
        checks++; if (err_multi_load !== 1'b1 || wb_we !== 4'b0000) begin failures++; $display("FAIL multi_sticky got err=%b we=%b exp err=1 we=0000", err_multi_load, wb_we); end
    endtask

    task automatic test_reset_mid_wait;
        drive(4'b0010, {7'd0, 7'd0, 7'd6, 7'd0}, {32'h0, 32'h0, 32'h66, 32'h0}, 4'b0010);
        tick;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstwait_pre got busy=%b exp=1", busy); end
        drive(4'b0000, '0, '0, 4'b0000);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || wb_we !== 4'b0000 || err_multi_load !== 1'b0) begin failures++; $display("FAIL rstwait_async got busy=%b we=%b err=%b exp 0 0000 0", busy, wb_we, err_multi_load); end
        checks++; if (wb_data !== 128'h0 || wb_rd !== 28'h0) begin failures++; $display("FAIL rstwait_bundle got rd=%h data=%h exp=0", wb_rd, wb_data); end
        @(negedge clk);
        rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFFFFFF;
        tick;
        mem_rvalid = 1'b0;
        checks++; if (busy !== 1'b0 || wb_we !== 4'b0000 || wb_data !== 128'h0) begin failures++; $display("FAIL rvalid_idle got busy=%b we=%b data=%h exp idle", busy, wb_we, wb_data); end
    endtask

    initial begin
        rst        = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        drive(4'b0000, '0, '0, 4'b0000);
        test_reset;
        test_basic;
        test_back_to_back;
        test_load;
        test_conflict;
        test_stall_flush;
        test_multi_load;
        test_reset_mid_wait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
